rx_rd_checker: RTL

// - RX PCS running-disparity checker; receive-side counterpart of the TX disparity FSM.
// - Sits between the RX deserializer (10-bit symbols at Bit_Rate_10) and the 10b/8b decoder.
// - Acquires running disparity (RD) from K28.5 commas, then tracks RD on every symbol.
// - Flags disparity and code-weight errors; drops lock after repeated bad symbols.

---
 rtl/rx_rd_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rx_rd_checker.sv
// rx_rd_checker: RX running-disparity checker that locks on K28.5 and flags disparity/weight errors.
// Define RD_ERR_CNT_EN to add the saturating Err_Cnt error counter output.
module rx_rd_checker #(
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 Bit_Rate_10,
    input  logic                 Rst,
    input  logic                 enable,
    input  logic [9:0]           Data_10_in,
    output logic [9:0]           Data_10_out,
    output logic                 RxValid,
    output logic                 RD_out,
    output logic                 Comma_Det,
    output logic                 Disp_Err,
    output logic                 Code_Err,
`ifdef RD_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] Err_Cnt,
`endif
    output logic                 Locked
);
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    localparam logic [9:0] K28_5_P = 10'b0011111010;
    localparam logic [9:0] K28_5_N = 10'b1100000101;

    state_t     state_q, state_d;
    logic       rd_q, rd_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       comma_q, comma_d;
    logic       disp_q, disp_d;
    logic       code_q, code_d;
    logic [3:0] w;
    logic       is_comma;
    logic       code_bad;
    logic       disp_bad;
`ifdef RD_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_q, err_d;
`endif

    assign w        = 4'($countones(Data_10_in));
    assign is_comma = (Data_10_in == K28_5_P) || (Data_10_in == K28_5_N);
    assign code_bad = (w < 4'd4) || (w > 4'd6);
    // A weight-6 symbol is only legal from RD-, a weight-4 symbol only from RD+.
    assign disp_bad = !code_bad && (((w == 4'd6) && rd_q) || ((w == 4'd4) && !rd_q));

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        comma_d = 1'b0;
        disp_d  = 1'b0;
        code_d  = 1'b0;
`ifdef RD_ERR_CNT_EN
        err_d   = err_q;
`endif
        if (enable) begin
            data_d  = Data_10_in;
            comma_d = is_comma;
            if (state_q == UNLOCKED) begin
                if (is_comma) begin
                    rd_d    = (Data_10_in == K28_5_P);
                    state_d = LOCKED;
                    cnt_d   = 4'd0;
                end
            end else begin
                valid_d = 1'b1;
                code_d  = code_bad;
                disp_d  = disp_bad;
                rd_d    = code_bad ? rd_q : (w == 4'd6) ? 1'b1 : (w == 4'd4) ? 1'b0 : rd_q;
                if (code_bad || disp_bad) begin
                    cnt_d   = (cnt_q == 4'(LOSS_THRESH - 1)) ? 4'd0 : cnt_q + 4'd1;
                    state_d = (cnt_q == 4'(LOSS_THRESH - 1)) ? UNLOCKED : LOCKED;
`ifdef RD_ERR_CNT_EN
                    err_d   = (&err_q) ? err_q : err_q + 1'b1;
`endif
                end else begin
                    cnt_d = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge Bit_Rate_10) begin
        if (Rst) begin
            state_q <= UNLOCKED;
            rd_q    <= 1'b0;
            cnt_q   <= 4'd0;
            data_q  <= 10'h000;
            valid_q <= 1'b0;
            comma_q <= 1'b0;
            disp_q  <= 1'b0;
            code_q  <= 1'b0;
`ifdef RD_ERR_CNT_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            comma_q <= comma_d;
            disp_q  <= disp_d;
            code_q  <= code_d;
`ifdef RD_ERR_CNT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign Data_10_out = data_q;
    assign RxValid     = valid_q;
    assign RD_out      = rd_q;
    assign Comma_Det   = comma_q;
    assign Disp_Err    = disp_q;
    assign Code_Err    = code_q;
    assign Locked      = (state_q == LOCKED);
`ifdef RD_ERR_CNT_EN
    assign Err_Cnt     = err_q;
`endif
endmodule
